// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg
//   Shared types and constants for the synchronous instruction memory.
//   - imem_state_e     : CLEAR (filling memory with NOPs) / RUN (fetch + program)
//   - NOP_INSN_DEFAULT : RV32I canonical NOP, addi x0,x0,0
//   - word_index()     : byte address -> word index (caller truncates to its width)
package instr_mem_pkg;

  typedef enum logic {CLEAR, RUN} imem_state_e;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h00000013;

  // Drops the two byte-offset bits. The result is 32 bits wide so the helper
  // serves any ADDR_W; callers cast it down to ADDR_W-2 bits, which keeps
  // every index inside the array (no out-of-range case exists).
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array
//   Single-write-port, single-read-port synchronous RAM, read-first.
//   Ports:
//     clk          : clock, rising edge
//     we/waddr/wdata : write port (word index)
//     re/raddr     : read enable / word index; rdata updates only when re=1
//     rdata        : registered read data (holds while re=0)
//   Contents are never reset.
module imem_array #(
  parameter int IDX_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // Both updates are non-blocking, so a read of the word being written in
  // the same cycle returns the old contents (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync
//   Synchronous-read instruction memory with a runtime programming port, a
//   valid/ready fetch interface with a one-entry response register,
//   misalignment fault reporting, and an automatic clear-to-NOP sequence.
//   Ports:
//     clk, reset        : clock (rising edge), asynchronous active-high reset
//     clear_req, busy   : restart clear sequence / high while clearing
//     req_valid/ready/addr          : fetch request (byte address)
//     rsp_valid/ready/data/fault    : fetch response, fault = misaligned
//     prog_we/ready/addr/data       : program write port (addr bits [1:0] ignored)
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int              ADDR_W   = 9,
  parameter int              INS_W    = 32,
  parameter logic [INS_W-1:0] NOP_INSN = INS_W'(NOP_INSN_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INS_W-1:0]  rsp_data,
  output logic              rsp_fault,
  input  logic              prog_we,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [INS_W-1:0]  prog_data
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  imem_state_e      state;
  logic [IDX_W-1:0] clr_idx;

  logic             rsp_loaded;  // a RAM read has landed since reset
  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] prog_idx;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [INS_W-1:0] ram_wdata;
  logic [INS_W-1:0] ram_rdata;

  assign req_idx  = IDX_W'(word_index(32'(req_addr)));
  assign prog_idx = IDX_W'(word_index(32'(prog_addr)));

  assign busy       = (state == CLEAR);
  assign prog_ready = (state == RUN);
  assign req_ready  = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept     = req_valid && req_ready;

  // Clear/run sequencer: one NOP written per CLEAR cycle, DEPTH cycles total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_req) begin
            clr_idx <= '0;
          end else if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= RUN;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Write port shared by the clear engine and the program port; program
  // writes are only honoured in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_idx;
    ram_wdata = prog_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = NOP_INSN;
    end else if (prog_we) begin
      ram_we = 1'b1;
    end
  end

  // Read only on accept, so the RAM output register doubles as the held
  // response data while the consumer stalls.
  imem_array #(
    .IDX_W  (IDX_W),
    .DATA_W (INS_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );

  // Response register: valid, fault and a "RAM data is meaningful" flag.
  // Reset clears all three, which forces rsp_data back to NOP_INSN at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_fault  <= 1'b0;
      rsp_loaded <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_fault  <= (req_addr[1:0] != 2'b00);
      rsp_loaded <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_data = (rsp_fault || !rsp_loaded) ? NOP_INSN : ram_rdata;

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the single-cycle/pipelined RISC-V core. Replaces the fixed combinational ROM.
- Adds a runtime programming port, so the bench or boot loader loads programs without recompiling.
- Adds a valid/ready fetch handshake with a one-entry registered response stage and misalignment fault reporting.
- Runs an automatic clear-to-NOP sequence after reset or on request.
- Sits between the PC/fetch unit and the decode stage.

Parameters:
- ADDR_W, 9, byte-address width. Memory depth DEPTH = 2**(ADDR_W-2) words (derived localparam, default 128).
- INS_W, 32, instruction word width.
- NOP_INSN, 32'h00000013, fill value (addi x0,x0,0). Also returned on faulted fetches.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  one-cycle pulse; restarts the clear-to-NOP sequence.
- busy  out  1  high while clearing.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when valid&&ready.
- req_addr  in  ADDR_W  fetch byte address (from PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  INS_W  fetched instruction.
- rsp_fault  out  1  fetch address misaligned (req_addr[1:0]!=0).
- prog_we  in  1  program-write strobe.
- prog_ready  out  1  program port accepting writes.
- prog_addr  in  ADDR_W  program byte address; bits [1:0] ignored.
- prog_data  in  INS_W  word to write.

Behaviour:
- State machine: CLEAR, RUN.
  - Reset → CLEAR with clr_idx=0.
  - CLEAR writes NOP_INSN to word clr_idx each cycle and increments clr_idx.
  - After writing index DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
  - clear_req in RUN → CLEAR with clr_idx=0 next cycle.
  - clear_req in CLEAR restarts clr_idx at 0.
- Reset values: state=CLEAR, busy=1, rsp_valid=0, rsp_data=NOP_INSN, rsp_fault=0, req_ready=0, prog_ready=0.
  - Reset mid-operation aborts everything, including any pending response.
  - Memory contents are not reset; they are overwritten by CLEAR.
- busy = (state==CLEAR). prog_ready = (state==RUN). prog_we while !prog_ready is ignored.
- Program write: when prog_we && prog_ready, mem[prog_addr[ADDR_W-1:2]] <= prog_data at the clock edge.
- Fetch handshake:
  - req_ready = (state==RUN) && (!rsp_valid || rsp_ready). This is combinational from state and registered rsp_valid, not from req_valid.
  - On accept (req_valid&&req_ready), the next cycle has rsp_valid=1 and rsp_data = mem[req_addr[ADDR_W-1:2]]. Latency is 1 cycle.
  - Back-to-back accepts give one response per cycle while rsp_ready=1.
  - If rsp_valid && !rsp_ready, rsp_data and rsp_fault hold stable and no new request is accepted.
  - If rsp_ready and there is no new accept, rsp_valid clears.
- Misaligned fetch (req_addr[1:0]!=0): the request is still accepted. Response has rsp_fault=1 and rsp_data=NOP_INSN.
- Simultaneous program write and fetch to the same word in the same cycle: read-first, so the response carries the old contents. A fetch in a later cycle sees the new word.
- Address wrap: the word index is ADDR_W-2 bits wide, so addresses cannot exceed the array. No out-of-range case exists.
- clear_req while a response is pending: rsp_valid is kept until consumed; req_ready=0 during CLEAR.

Decomposition:
- Package instr_mem_pkg holds:
  - typedef enum logic {CLEAR, RUN} imem_state_e;
  - the NOP_INSN default constant (RV32I canonical NOP);
  - a function word_index(addr) returning addr[ADDR_W-1:2].
- One natural sub-module: imem_array, a single-write-port, single-read-port synchronous RAM with read-first semantics. Write port is muxed between the clear engine and the program port. The top holds the FSM, handshake, and response register.

Test Plan:
- Assert reset 3 cycles, release → busy=1 for exactly 128 cycles, then prog_ready=1. A fetch of addr 0x04 returns 32'h00000013, rsp_fault=0.
- Program words 0→32'h00100093, 1→32'h00200113, 2→32'h00208433. Fetch 0x0,0x4,0x8 back-to-back with rsp_ready=1 → three consecutive rsp_valid cycles with the programmed data in order, one cycle after each accept.
- Fetch 0x4, hold rsp_ready=0 for 3 cycles → rsp_data stays 32'h00200113, req_ready=0 throughout. Raise rsp_ready → next request accepted the same cycle.
- Fetch 0x6 → rsp_fault=1, rsp_data=32'h00000013. Following aligned fetch of 0x8 → rsp_fault=0, data 32'h00208433.
- Same cycle: prog_we to word 3 with 32'h404404b3 and fetch 0xC → response gives the old value 32'h00000013. Refetch → 32'h404404b3.
- clear_req in RUN, then assert reset during cycle 50 of CLEAR → rsp_valid=0 immediately (asynchronous), full 128-cycle CLEAR restarts, and word 3 reads 32'h00000013 afterwards.
